data_mem_ctrl: RTL
==================

# data_mem_ctrl

Memory-stage responder for the load/store requests produced by the control unit (`data_mem_en`, `data_mem_wen`, `byte_en`) and the ALU address.
- Executes `lw`, `sw`, `lb` and `sb` against a word-wide synchronous data RAM that has no byte strobes, so `sb` is done as read-modify-write.
- Stalls the pipeline for every request until the access completes.
- Sits between the EX/MEM pipeline register and the data RAM.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width driven to the RAM.
- `WAIT`, default 1: RAM read latency in cycles, legal range 1..4.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_en`  in  1  access request (from `data_mem_en`).
- `req_wen`  in  1  1 = store, 0 = load.
- `req_byte`  in  1  1 = byte access (`lb`/`sb`), 0 = word access.
- `req_addr`  in  32  byte address from ALU.
- `req_wdata`  in  32  store data; `sb` uses bits [7:0].
- `stall`  out  1  hold pipeline (combinational).
- `ack`  out  1  one-cycle completion pulse.
- `rdata`  out  32  load result, registered, valid when `ack`=1 for loads.
- `misalign`  out  1  misaligned word access flag.
- `mem_ce`  out  1  RAM chip enable.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  `ADDR_W`  RAM word address, equal to latched `req_addr[ADDR_W+1:2]`; upper bits ignored (wraps).
- `mem_wdata`  out  32  RAM write data.
- `mem_rdata`  in  32  RAM read data; valid `WAIT` cycles after the cycle in which `mem_ce`=1 and `mem_we`=0.

## Operation
- FSM states: IDLE, RD, RWAIT, RESP, WR.
- **IDLE**
  - `req_en`=1 latches `req_*` and sets `stall`=1.
  - Next state: WR for `sw`; RD for `lw`, `lb` and `sb`.
  - `req_en`=0 gives `stall`=0 and no action.
- **RD**: `mem_ce`=1, `mem_we`=0, one cycle. Then RWAIT, or directly to capture if `WAIT`=1.
- **RWAIT**: counts `WAIT`-1 cycles. `mem_rdata` is captured at the end of cycle RD+`WAIT`.
- **After capture**
  - Loads go to RESP.
  - `sb` merges latched `wdata[7:0]` into the selected lane of the captured word and goes to WR.
- **RESP**: `ack`=1, `stall`=0, `rdata` holds the result. Next state IDLE.
- **WR**: `mem_ce`=1, `mem_we`=1, `ack`=1, `stall`=0. `mem_wdata` = `req_wdata` (`sw`) or the merged word (`sb`). Next state IDLE.
- Byte lanes are big-endian: `addr[1:0]`=0 selects [31:24], 1 selects [23:16], 2 selects [15:8], 3 selects [7:0].
- `lb` result is the selected byte sign-extended to 32 bits.
- The latched request is authoritative. Changes on `req_*` after acceptance are ignored until return to IDLE.
- Outside RD and WR, `mem_ce` and `mem_we` are 0.

## Timing
- Cycle 0 is the IDLE cycle in which the request is seen.
- **`sw`**: stall in cycle 0; write and `ack` in cycle 1.
- **`lw`/`lb`**: stall in cycles 0..`WAIT`+1; `ack` and `rdata` in cycle `WAIT`+2. With `WAIT`=1, `ack` is in cycle 3.
- **`sb`**: stall in cycles 0..`WAIT`+1; write and `ack` in cycle `WAIT`+2.
- A back-to-back request is accepted in the cycle after `ack`, once the FSM is back in IDLE.
- **Reset values**: state IDLE, counter 0. `stall`, `ack`, `misalign`, `mem_ce`, `mem_we` = 0. `rdata`, `mem_addr`, `mem_wdata` = 0.
- **Reset mid-operation**: aborts immediately. No RAM write occurs unless the WR edge completed before reset. `stall` drops with reset.

## Configuration
- **`MISALIGN_TRAP_EN` defined**
  - Applies to word access (`req_byte`=0) with `req_addr[1:0]`≠0.
  - IDLE goes to RESP with no RAM access; `mem_ce` stays 0.
  - In cycle 1: `ack`=1, `misalign`=1, `rdata`=0.
  - Stall in cycle 0 only.
- **`MISALIGN_TRAP_EN` undefined**
  - `addr[1:0]` is ignored for word accesses.
  - `misalign` is tied 0.

## Test plan
- **Reset**: hold `rst_n`=0 with `req_en`=1 → every output is 0 and `stall`=0; release → no access until a new request is seen.
- **`sw`**, `WAIT`=1, addr 0x10, data 0xDEADBEEF → cycle 1 shows `mem_ce`=`mem_we`=1, `mem_addr`=4, `mem_wdata`=0xDEADBEEF, `ack`=1; `stall` is high only in cycle 0.
- **`lw`**, addr 0x10, RAM returns 0xDEADBEEF → `stall` high in cycles 0-2; cycle 3 shows `ack`=1, `rdata`=0xDEADBEEF. Repeat with `WAIT`=3 → `ack` in cycle 5.
- **`lb`**, RAM word 0x12345680:
  - addr 0x13 → `rdata`=0xFFFFFF80.
  - addr 0x11 → `rdata`=0x00000034.
- **`sb`**, addr 0x12, `wdata`=0x000000AB, RAM word 0x11223344 → one RAM read, then a write of 0x1122AB44 with `ack` in cycle `WAIT`+2.
- **Abort and trap**:
  - Assert `rst_n`=0 during the `sb` read phase → `mem_we` is never asserted and the state is IDLE.
  - With `MISALIGN_TRAP_EN`, `lw` at 0x11 → cycle 1 shows `ack`=`misalign`=1, `rdata`=0, and `mem_ce` is never asserted.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: memory-stage load/store responder for lw/sw/lb/sb.
// Word-wide synchronous RAM without byte strobes; sb is read-modify-write.
//
// Parameters:
//   ADDR_W    RAM word-address width (default 10)
//   WAIT      RAM read latency in cycles, 1..4 (default 1)
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_en/req_wen    request valid / store (1) or load (0)
//   req_byte          byte access (lb/sb)
//   req_addr          byte address from ALU
//   req_wdata         store data (sb uses [7:0])
//   stall             hold pipeline (combinational)
//   ack               one-cycle completion pulse
//   rdata             registered load result
//   misalign          misaligned word access flag
//   mem_ce/mem_we     RAM chip/write enable
//   mem_addr          RAM word address (req_addr[ADDR_W+1:2], wraps)
//   mem_wdata         RAM write data
//   mem_rdata         RAM read data, WAIT cycles after the read cycle
// Build option:
//   MISALIGN_TRAP_EN  trap misaligned word accesses instead of
//                     ignoring addr[1:0]; misalign is 0 otherwise.

module data_mem_ctrl #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_en,
    input  logic              req_wen,
    input  logic              req_byte,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RWAIT,
        S_RESP,
        S_WR
    } state_t;

    // RWAIT spans WAIT cycles; the last one is the capture cycle.
    localparam logic [1:0] L_CNT = 2'(WAIT - 1);

    state_t              r_state;
    logic [1:0]          r_cnt;
    logic                r_wen;
    logic                r_byte;
    logic [1:0]          r_lane;
    logic [7:0]          r_wbyte;
    logic                r_ack;
    logic                r_ce;
    logic                r_we;
    logic                r_mis;
    logic [31:0]         r_rdata;
    logic [31:0]         r_wdata;
    logic [ADDR_W-1:0]   r_addr;

    logic                w_trap;
    logic [7:0]          w_lane_byte;
    logic [31:0]         w_merged;
    logic                w_unused_addr;

    assign w_unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};

`ifdef MISALIGN_TRAP_EN
    assign w_trap = ~req_byte & (|req_addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    // Big-endian lanes: lane 0 is the most significant byte.
    always_comb begin
        w_lane_byte = mem_rdata[7:0];
        w_merged    = mem_rdata;
        unique case (r_lane)
            2'd0: begin
                w_lane_byte     = mem_rdata[31:24];
                w_merged[31:24] = r_wbyte;
            end
            2'd1: begin
                w_lane_byte     = mem_rdata[23:16];
                w_merged[23:16] = r_wbyte;
            end
            2'd2: begin
                w_lane_byte     = mem_rdata[15:8];
                w_merged[15:8]  = r_wbyte;
            end
            default: begin
                w_lane_byte     = mem_rdata[7:0];
                w_merged[7:0]   = r_wbyte;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_wen   <= 1'b0;
            r_byte  <= 1'b0;
            r_lane  <= 2'd0;
            r_wbyte <= 8'd0;
            r_ack   <= 1'b0;
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            r_mis   <= 1'b0;
            r_rdata <= 32'd0;
            r_wdata <= 32'd0;
            r_addr  <= '0;
        end else begin
            r_ack <= 1'b0;
            r_ce  <= 1'b0;
            r_we  <= 1'b0;
            r_mis <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (req_en) begin
                        r_wen   <= req_wen;
                        r_byte  <= req_byte;
                        r_lane  <= req_addr[1:0];
                        r_wbyte <= req_wdata[7:0];
                        r_addr  <= req_addr[ADDR_W+1:2];
                        if (w_trap) begin
                            r_state <= S_RESP;
                            r_ack   <= 1'b1;
                            r_mis   <= 1'b1;
                            r_rdata <= 32'd0;
                        end else if (req_wen && !req_byte) begin
                            r_state <= S_WR;
                            r_ce    <= 1'b1;
                            r_we    <= 1'b1;
                            r_ack   <= 1'b1;
                            r_wdata <= req_wdata;
                        end else begin
                            r_state <= S_RD;
                            r_ce    <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_RWAIT;
                    r_cnt   <= L_CNT;
                end
                S_RWAIT: begin
                    if (r_cnt != 2'd0) begin
                        r_cnt <= r_cnt - 2'd1;
                    end else if (r_wen) begin
                        // sb: write back the merged word
                        r_state <= S_WR;
                        r_wdata <= w_merged;
                        r_ce    <= 1'b1;
                        r_we    <= 1'b1;
                        r_ack   <= 1'b1;
                    end else begin
                        r_state <= S_RESP;
                        r_ack   <= 1'b1;
                        r_rdata <= r_byte
                            ? {{24{w_lane_byte[7]}}, w_lane_byte}
                            : mem_rdata;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                S_WR:    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gated with rst_n so stall drops the moment reset asserts.
    assign stall = rst_n & (((r_state == S_IDLE) & req_en)
                 | (r_state == S_RD)
                 | (r_state == S_RWAIT));

    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign misalign  = r_mis;
    assign mem_ce    = r_ce;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
